// File: rtl/tnn_pkg.sv
// Shared types and default geometry for the TNN frame driver.
// The defaults match the cardio tnn1 classifier (19 features, 3 classes).
package tnn_pkg;

  typedef enum logic [1:0] {
    LOAD,
    DRAIN,
    SETTLE,
    RESULT
  } tnn_state_e;

  localparam int DEF_FEAT_CNT  = 19;
  localparam int DEF_CLASS_CNT = 3;
  localparam int PRED_BITS     = $clog2(DEF_CLASS_CNT);
  localparam int CNT_BITS      = $clog2(DEF_FEAT_CNT);

endpackage

// File: rtl/tnn_feat_stage.sv
// Staging buffer for incoming feature beats plus the registered parallel copy
// that drives the classifier's flat features bus.
module tnn_feat_stage #(
  parameter int FEAT_CNT  = 19,
  parameter int FEAT_BITS = 4,
  parameter int CNT_W     = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [CNT_W-1:0]              wr_idx,
  input  logic [FEAT_BITS-1:0]          wr_data,
  input  logic                          copy_en,
  output logic [FEAT_CNT*FEAT_BITS-1:0] features
);

  // The final beat goes straight from wr_data into the copy, so staging only
  // needs room for the first FEAT_CNT-1 features.
  logic [FEAT_BITS-1:0] staging [FEAT_CNT-1];

  // NOTE: staging is a plain memory with no reset; a copy only happens after
  // every entry has been rewritten by the current frame.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      staging[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      features <= '0;
    end else if (copy_en) begin
      for (int k = 0; k < FEAT_CNT - 1; k++) begin
        features[k*FEAT_BITS +: FEAT_BITS] <= staging[k];
      end
      features[(FEAT_CNT-1)*FEAT_BITS +: FEAT_BITS] <= wr_data;
    end
  end

endmodule

// File: rtl/tnn_frame_driver.sv
// Sequential wrapper around a combinational TNN classifier: streams in one
// frame, presents it in parallel, waits a settle time, returns the class.
module tnn_frame_driver
  import tnn_pkg::*;
#(
  parameter int FEAT_CNT      = DEF_FEAT_CNT,
  parameter int FEAT_BITS     = 4,
  parameter int CLASS_CNT     = DEF_CLASS_CNT,
  parameter int SETTLE_CYCLES = 2,
  parameter int IDX_BITS      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [FEAT_BITS-1:0]          in_feat,
  input  logic                          in_last,
  output logic [FEAT_CNT*FEAT_BITS-1:0] features,
  input  logic [$clog2(CLASS_CNT)-1:0]  prediction,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(CLASS_CNT)-1:0]  out_class,
  output logic [IDX_BITS-1:0]           out_idx,
  output logic                          frame_err
);

  localparam int CNT_W  = $clog2(FEAT_CNT);
  localparam int PRED_W = $clog2(CLASS_CNT);
  localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FEAT_CNT - 1);
  localparam logic [SET_W-1:0] SET_LOAD  = SET_W'(SETTLE_CYCLES - 1);

  tnn_state_e          state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [SET_W-1:0]    settle_cnt, settle_d;
  logic [IDX_BITS-1:0] frame_idx, frame_idx_d;
  logic                in_ready_d, out_valid_d, frame_err_d;
  logic [PRED_W-1:0]   out_class_d;
  logic [IDX_BITS-1:0] out_idx_d;
  logic                accept, wr_en, copy_en;

  assign accept = in_valid && in_ready;

  tnn_feat_stage #(
    .FEAT_CNT  (FEAT_CNT),
    .FEAT_BITS (FEAT_BITS),
    .CNT_W     (CNT_W)
  ) u_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_idx   (cnt),
    .wr_data  (in_feat),
    .copy_en  (copy_en),
    .features (features)
  );

  // NOTE: every output of this block gets a default before the case so that
  // no path leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    settle_d    = settle_cnt;
    frame_idx_d = frame_idx;
    out_valid_d = out_valid;
    out_class_d = out_class;
    out_idx_d   = out_idx;
    frame_err_d = 1'b0;
    wr_en       = 1'b0;
    copy_en     = 1'b0;

    case (state)
      LOAD: begin
        if (accept) begin
          if (cnt == LAST_BEAT) begin
            cnt_d = '0;
            if (in_last) begin
              copy_en  = 1'b1;
              settle_d = SET_LOAD;
              state_d  = SETTLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = DRAIN;
            end
          end else if (in_last) begin
            frame_err_d = 1'b1;
            cnt_d       = '0;
          end else begin
            wr_en = 1'b1;
            cnt_d = cnt + 1'b1;
          end
        end
      end
      DRAIN: begin
        // Swallow the tail of an over-long frame without a second error.
        if (accept && in_last) begin
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      SETTLE: begin
        if (settle_cnt != '0) begin
          settle_d = settle_cnt - 1'b1;
        end else begin
          out_class_d = prediction;
          out_idx_d   = frame_idx;
          frame_idx_d = frame_idx + 1'b1;
          out_valid_d = 1'b1;
          state_d     = RESULT;
        end
      end
      RESULT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase

    // in_ready is registered, so it follows the state being entered.
    in_ready_d = (state_d == LOAD) || (state_d == DRAIN);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD;
      cnt        <= '0;
      settle_cnt <= '0;
      frame_idx  <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_class  <= '0;
      out_idx    <= '0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      settle_cnt <= settle_d;
      frame_idx  <= frame_idx_d;
      in_ready   <= in_ready_d;
      out_valid  <= out_valid_d;
      out_class  <= out_class_d;
      out_idx    <= out_idx_d;
      frame_err  <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_tnn_frame_driver.sv
// Scoreboard bench for tnn_frame_driver driving a stand-in weighted-sum
// classifier; expected results are queued as frames are sent.
module tb_tnn_frame_driver;
  import tnn_pkg::*;

  localparam int FC = DEF_FEAT_CNT;
  localparam int FB = 4;
  localparam int CC = DEF_CLASS_CNT;
  localparam int SC = 2;
  localparam int IB = 8;   // narrow index so the wrap is reached in a short run
  localparam int FW = FC * FB;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [FB-1:0]     in_feat = '0;
  logic              in_last = 1'b0;
  logic [FW-1:0]     features;
  logic [PRED_BITS-1:0] prediction;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [PRED_BITS-1:0] out_class;
  logic [IB-1:0]     out_idx;
  logic              frame_err;

  always #5 clk = ~clk;

  tnn_frame_driver #(
    .FEAT_CNT      (FC),
    .FEAT_BITS     (FB),
    .CLASS_CNT     (CC),
    .SETTLE_CYCLES (SC),
    .IDX_BITS      (IB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_feat    (in_feat),
    .in_last    (in_last),
    .features   (features),
    .prediction (prediction),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_class  (out_class),
    .out_idx    (out_idx),
    .frame_err  (frame_err)
  );

  // Stand-in classifier: position-weighted feature sum modulo the class count.
  always_comb begin
    int s;
    s = 0;
    for (int k = 0; k < FC; k++) s += (k + 1) * int'(features[k*FB +: FB]);
    prediction = PRED_BITS'(s % CC);
  end

  function automatic logic [PRED_BITS-1:0] ref_class(input logic [FW-1:0] v);
    int s;
    s = 0;
    for (int k = 0; k < FC; k++) s += (k + 1) * int'(v[k*FB +: FB]);
    return PRED_BITS'(s % CC);
  endfunction

  typedef struct {
    logic [PRED_BITS-1:0] cls;
    logic [IB-1:0]        idx;
    logic [FW-1:0]        feat;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            n_out = 0;
  int            n_good = 0;
  int            err_pulses = 0;
  int            n_wrap = 0;
  logic [IB-1:0] exp_idx = '0;
  logic [IB-1:0] prev_idx = '0;
  logic [FW-1:0] last_good = '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: counts error pulses and scores every result handshake.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (frame_err) err_pulses++;
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          check("out_class", out_class, e.cls);
          check("out_idx", out_idx, e.idx);
          check("features", features, e.feat);
          if (out_idx == '0 && prev_idx == '1) n_wrap++;
          prev_idx = out_idx;
        end
      end
    end
  end

  task automatic send_beat(input logic [FB-1:0] v, input logic last);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_feat  = v;
    in_last  = last;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int n, input int last_at, input int gap_max,
                            input bit rnd, output logic [FW-1:0] pk);
    logic [FB-1:0] v;
    pk = '0;
    for (int i = 0; i < n; i++) begin
      v = rnd ? FB'($urandom_range(0, 15)) : FB'(i % 16);
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) begin
          @(posedge clk); #1;
        end
      end
      if (i < FC) pk[i*FB +: FB] = v;
      send_beat(v, i == last_at);
    end
  endtask

  task automatic good_frame(input int gap_max, input bit rnd);
    logic [FW-1:0] pk;
    exp_t e;
    send_frame(FC, FC - 1, gap_max, rnd, pk);
    e.cls  = ref_class(pk);
    e.idx  = exp_idx;
    e.feat = pk;
    sb.push_back(e);
    exp_idx++;
    n_good++;
    last_good = pk;
  endtask

  task automatic wait_drain(input string tag);
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check(tag, sb.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_class"}, out_class, 0);
    check({tag, "_out_idx"}, out_idx, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_features"}, features, 0);
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [FW-1:0]        pk;
    logic [PRED_BITS-1:0] hold_cls;
    logic [IB-1:0]        hold_idx;
    int                   e0, o0, guard;

    // Reset
    #12;
    check_reset_values("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Single frame k%16, latency of SC cycles after last accept
    good_frame(0, 1'b0);
    @(negedge clk);
    check("t1_features", features, last_good);
    check("t1_lat1", out_valid, 0);
    @(negedge clk);
    check("t1_lat2", out_valid, 0);
    @(negedge clk);
    check("t1_lat3", out_valid, 1);
    wait_drain("t1_drain");

    // Backpressure: outputs held, in_ready low, release reopens input
    out_ready = 1'b0;
    good_frame(0, 1'b1);
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("bp_valid", out_valid, 1);
    hold_cls = out_class;
    hold_idx = out_idx;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_class", out_class, hold_cls);
      check("bp_hold_idx", out_idx, hold_idx);
      check("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_before", in_ready, 0);
    @(negedge clk);
    check("bp_ready_after", in_ready, 1);
    check("bp_valid_after", out_valid, 0);
    @(posedge clk); #1;

    // Short frame: one error pulse, no result, features untouched
    e0 = err_pulses;
    o0 = n_out;
    send_frame(6, 5, 0, 1'b1, pk);
    repeat (6) @(negedge clk);
    check("short_err", err_pulses - e0, 1);
    check("short_no_out", n_out - o0, 0);
    check("short_features", features, last_good);
    @(posedge clk); #1;
    good_frame(0, 1'b1);
    wait_drain("short_next_drain");

    // Long frame: one error pulse, tail drained, features untouched
    e0 = err_pulses;
    o0 = n_out;
    send_frame(22, 21, 0, 1'b1, pk);
    repeat (6) @(negedge clk);
    check("long_err", err_pulses - e0, 1);
    check("long_no_out", n_out - o0, 0);
    check("long_features", features, last_good);
    @(posedge clk); #1;
    good_frame(0, 1'b1);
    wait_drain("long_next_drain");

    // Reset mid-load: asynchronous clear, then a clean frame from index 0
    send_frame(11, 99, 0, 1'b1, pk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    exp_idx   = '0;
    prev_idx  = '0;
    last_good = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    good_frame(0, 1'b1);
    wait_drain("midrst_drain");

    // Back-to-back frames, some with in_valid gaps, through the index wrap
    for (int f = 0; f < 300; f++) begin
      good_frame((f % 4 == 1) ? 3 : 0, 1'b1);
    end
    wait_drain("burst_drain");
    check("idx_wrap", n_wrap, 1);
    check("result_count", n_out, n_good);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
